// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scanner channel selector.
package mux_scan_pkg;

  typedef enum logic {
    S_DIRECT = 1'b0,
    S_SCAN   = 1'b1
  } state_t;

  // Channel address width; never narrower than one bit.
  function automatic int sel_width(input int channels);
    return (channels > 2) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational search for the lowest unmasked channel above cur, wrapping around.
// none is set (and nxt holds cur) when every channel is masked.
module mux_scan_next_ch
  import mux_scan_pkg::*;
#(
  parameter  int CHANNELS = 16,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] mask,
  input  logic [SEL_W-1:0]    cur,
  output logic [SEL_W-1:0]    nxt,
  output logic                none
);

  logic [SEL_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    nxt  = cur;
    none = 1'b1;
    idx  = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      idx = SEL_W'((int'(cur) + i) % CHANNELS);
      if (!mask[idx]) begin
        nxt  = idx;
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scanner.sv
// Registered N-channel selector with strobe, optional inversion and auto-scan; one-cycle latency.
// Channel skip mask in scan mode is built only with MUX_SCAN_MASK_EN defined.
module mux_scanner
  import mux_scan_pkg::*;
#(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 16,
  parameter  int DWELL_W  = 8,
  parameter  int INVERT   = 1,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      strobe,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      scan_en,
  input  logic [DWELL_W-1:0]        dwell,
`ifdef MUX_SCAN_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      scan_wrap
);

  localparam int               NSLOT   = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   NCH     = (SEL_W + 1)'(CHANNELS);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [WIDTH-1:0]   out_data_d;
  logic [SEL_W-1:0]   out_ch_d;
  logic               out_valid_d, scan_wrap_d;

  logic [SEL_W-1:0]   first_ch, cur_ch, next_ch;
  logic [DWELL_W-1:0] cur_dcnt;
  logic               entry, none_unmasked, last_in_pass, sel_ok;
  logic [WIDTH-1:0]   sel_dat, scan_dat;

  // Pad the channel view to a power of two so any address indexes safely.
  logic [WIDTH-1:0] chan [NSLOT];
  for (genvar k = 0; k < NSLOT; k++) begin : g_chan
    if (k < CHANNELS) begin : g_real
      assign chan[k] = data_in[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chan[k] = '0;
    end
  end

  assign sel_ok   = ({1'b0, sel} < NCH);
  assign sel_dat  = (INVERT != 0) ? ~chan[sel]    : chan[sel];
  assign scan_dat = (INVERT != 0) ? ~chan[cur_ch] : chan[cur_ch];

  // The entry edge is itself the first scan cycle, seeded with the first channel and a full dwell.
  assign entry    = (state_q == S_DIRECT);
  assign cur_ch   = entry ? first_ch : ch_q;
  assign cur_dcnt = entry ? dwell    : dcnt_q;

`ifdef MUX_SCAN_MASK_EN
  logic [SEL_W-1:0] first_raw;
  logic             first_none, next_none;

  mux_scan_next_ch #(.CHANNELS(CHANNELS)) u_first (
    .mask (ch_mask),
    .cur  (LAST_CH),
    .nxt  (first_raw),
    .none (first_none)
  );

  mux_scan_next_ch #(.CHANNELS(CHANNELS)) u_next (
    .mask (ch_mask),
    .cur  (cur_ch),
    .nxt  (next_ch),
    .none (next_none)
  );

  assign first_ch      = first_none ? '0 : first_raw;
  assign none_unmasked = first_none | next_none;
  assign last_in_pass  = (next_ch <= cur_ch);
`else
  assign first_ch      = '0;
  assign next_ch       = (cur_ch == LAST_CH) ? '0 : cur_ch + SEL_W'(1);
  assign none_unmasked = 1'b0;
  assign last_in_pass  = (cur_ch == LAST_CH);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_DIRECT;
      ch_q      <= '0;
      dcnt_q    <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      dcnt_q    <= dcnt_d;
      out_data  <= out_data_d;
      out_ch    <= out_ch_d;
      out_valid <= out_valid_d;
      scan_wrap <= scan_wrap_d;
    end
  end

  always_comb begin
    state_d = (scan_en && !strobe) ? S_SCAN : S_DIRECT;
  end

  always_comb begin
    out_data_d  = '0;
    out_ch_d    = '0;
    out_valid_d = 1'b0;
    scan_wrap_d = 1'b0;
    ch_d        = '0;
    dcnt_d      = '0;
    if (state_d == S_SCAN) begin
      out_data_d = scan_dat;
      out_ch_d   = cur_ch;
      ch_d       = cur_ch;
      if (cur_dcnt != '0) begin
        dcnt_d = cur_dcnt - DWELL_W'(1);
      end else begin
        dcnt_d = dwell;
        if (!none_unmasked) begin
          out_valid_d = 1'b1;
          scan_wrap_d = last_in_pass;
          ch_d        = next_ch;
        end
      end
    end else if (!strobe) begin
      out_ch_d = sel;
      if (sel_ok) begin
        out_data_d  = sel_dat;
        out_valid_d = 1'b1;
      end
    end
  end

endmodule

// File: doc/mux_scanner.md
# mux_scanner

Registered, parametrised N-channel data selector with strobe and optional output inversion. Adds an auto-scan mode that steps through channels with a programmable dwell time and flags each sample. It sits between a bank of parallel data sources and a single downstream sampling consumer, and replaces hand-wired 16:1 selector chips in new designs.

## Interface
Parameters:
- WIDTH, 1: bits per channel.
- CHANNELS, 16: number of input channels; must be at least 2.
- DWELL_W, 8: width of the dwell count.
- INVERT, 1: 1 gives inverted output data (~selected), 0 gives true data.
- SEL_W, derived: $clog2(CHANNELS); a localparam, not overridable.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- strobe  in  1  active-high disable.
- sel  in  SEL_W  channel address in direct mode.
- scan_en  in  1  1 selects scan mode, 0 selects direct mode.
- dwell  in  DWELL_W  extra cycles spent on each channel in scan mode.
- ch_mask  in  CHANNELS  1 means skip the channel; present only with MUX_SCAN_MASK_EN.
- out_data  out  WIDTH  registered selected data.
- out_ch  out  SEL_W  channel that produced out_data.
- out_valid  out  1  out_data is a valid sample.
- scan_wrap  out  1  one-cycle pulse when a full scan pass completes.

## Operation
- State machine with two states, S_DIRECT and S_SCAN. The state is S_SCAN only when scan_en=1 and strobe=0 at the clock edge; otherwise it is S_DIRECT.
- Selected data is data_in[ch], inverted when INVERT=1.
- **Direct mode:** every cycle:
  - out_data gets the selected data for sel.
  - out_ch gets sel.
  - out_valid gets 1.
  - If sel >= CHANNELS: out_data gets 0 and out_valid gets 0.
- **Scan mode:**
  - Internal registers: channel counter ch and dwell counter dcnt.
  - On the S_DIRECT to S_SCAN transition: ch loads 0 (or the first unmasked channel) and dcnt loads dwell.
  - Every scan cycle: out_data gets the selected data for ch, and out_ch gets ch.
  - When dcnt != 0: dcnt decrements and out_valid gets 0.
  - When dcnt == 0: out_valid gets 1 for one cycle, ch advances, and dcnt reloads from dwell.
  - dwell=0 therefore gives one sample per cycle. dwell=D gives one sample every D+1 cycles.
- **Wrap:** ch advances from CHANNELS-1 (or the last unmasked channel) back to the first channel. scan_wrap is 1 in the same cycle as out_valid for that last channel.
- **Strobe:**
  - While strobe=1: out_data is 0, out_valid is 0, scan_wrap is 0, and ch and dcnt are cleared.
  - When strobe drops with scan_en=1, scanning restarts from the first channel.
- **scan_en falling mid-scan:** S_DIRECT from the next edge. ch and dcnt clear. No partial sample is flagged.
- **dwell changes mid-dwell:** the new value takes effect at the next reload only.

## Timing
- Reset: all outputs 0, state S_DIRECT, ch=0, dcnt=0.
- Latency is exactly one cycle from data_in, sel and strobe to out_data and out_valid.
- There is no combinational path from inputs to outputs.
- strobe has priority over scan_en, and scan_en has priority over sel.
- Asserting rst mid-scan returns every register to its reset value immediately. After release, the first edge behaves as a fresh entry into the state given by scan_en and strobe.

## Configuration
- Macro: MUX_SCAN_MASK_EN.
- **Defined:**
  - The ch_mask port exists.
  - Scan skips channels whose mask bit is 1. The next channel is the lowest unmasked index above ch, wrapping around.
  - If all channels are masked: out_valid and scan_wrap stay 0, and ch holds.
  - If exactly one channel is unmasked: every sample also pulses scan_wrap.
  - Direct mode ignores ch_mask.
- **Undefined:** the ch_mask port is absent and all channels are scanned in order.

## Structure
- Package mux_scan_pkg holds:
  - the state enum typedef (S_DIRECT, S_SCAN);
  - a helper function for the SEL_W calculation.
- Sub-module mux_scan_next_ch is compiled only under MUX_SCAN_MASK_EN:
  - it is combinational;
  - it finds the next unmasked channel after ch, with wraparound, and a none-found flag;
  - it is parametrised by CHANNELS.

## Test plan
- Reset then direct mode, CHANNELS=16, WIDTH=1, INVERT=1, data_in=16'hA5A5: sel=0 gives out_data=0 after 1 cycle; sel=1 gives out_data=1.
- strobe=1 with any sel: out_data=0 and out_valid=0 from the next cycle. Drop strobe: valid resumes one cycle later.
- Scan, dwell=2, CHANNELS=4: out_valid pulses every 3rd cycle with out_ch 0,1,2,3,0. scan_wrap pulses together with out_ch=3.
- Scan, dwell=0: out_valid is held at 1, out_ch increments every cycle, and scan_wrap pulses every 4th cycle. Drop scan_en mid-pass: direct mode next cycle and ch=0.
- With MUX_SCAN_MASK_EN, ch_mask=4'b0101: out_ch sequence is 1,3,1,3 and scan_wrap pulses on 3. With ch_mask=4'b1111: out_valid stays 0.
- Assert rst mid-dwell: all outputs go to 0 asynchronously. After release, scan restarts at channel 0 with a full dwell.
